click_classifier: RTL
=====================

CLICK_CLASSIFIER -- requirements
Module: click_classifier

Interface
REQ-001 SHALL have parameter CLICK_WINDOW, default 25_000_000: inter-click window in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter MAX_CLICKS, default 3: saturation value of the click count; legal range >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port pls_in, input, 1: one-cycle debounced press pulse from the upstream debouncer.
REQ-006 SHALL have port evt_valid, output, 1: a classified click event is presented.
REQ-007 SHALL have port evt_ready, input, 1: the consumer accepts the event.
REQ-008 SHALL have port evt_clicks, output, CNT_W = $clog2(MAX_CLICKS+1): number of clicks in the event, range 1..MAX_CLICKS.
REQ-009 SHALL have port evt_drop, output, 1: one-cycle pulse when an input pulse is discarded.

Function
REQ-010 SHALL implement FSM states IDLE, COUNT and EMIT.
REQ-011 In IDLE, pls_in SHALL load clicks=1, clear the timer and move to COUNT.
REQ-012 In COUNT, pls_in SHALL set clicks=min(clicks+1, MAX_CLICKS) and clear the timer; otherwise the timer SHALL increment.
REQ-013 In COUNT, when the timer equals CLICK_WINDOW-1 and pls_in=0, the FSM SHALL move to EMIT; evt_valid SHALL therefore rise exactly CLICK_WINDOW cycles after the edge that sampled the last pulse.
REQ-014 A pulse at the timeout cycle SHALL take priority, count as a click and restart the window.
REQ-015 Saturation at MAX_CLICKS SHALL NOT end the window early; further pulses are absorbed without evt_drop.
REQ-016 In EMIT, evt_valid=1 and evt_clicks SHALL hold stable until the cycle with evt_valid&&evt_ready.
REQ-017 A handshake with pls_in=0 SHALL move the FSM to IDLE, and evt_valid SHALL be 0 the next cycle.
REQ-018 A handshake with pls_in=1 in the same cycle SHALL move the FSM to COUNT with clicks=1, with no loss and no evt_drop.
REQ-019 pls_in=1 in EMIT without evt_ready SHALL be discarded, and evt_drop SHALL be 1 on the following cycle.
REQ-020 evt_clicks SHALL be 0 whenever evt_valid=0.
REQ-021 The timer SHALL be $clog2(CLICK_WINDOW) bits wide and SHALL never wrap.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, clicks=0, timer=0, evt_valid=0, evt_clicks=0 and evt_drop=0.
REQ-023 Reset mid-window or mid-EMIT SHALL discard the partial or pending event; no event SHALL be emitted after release.
REQ-024 The first pls_in accepted after release SHALL be the one sampled on the first rising edge with rst_n high.

Configuration
REQ-025 With macro CLICK_CLASSIFIER_DROP_CNT_EN defined, the block SHALL add output drop_cnt (8 bits): a saturating count of evt_drop pulses, reset to 0, held at 255.
REQ-026 Without CLICK_CLASSIFIER_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; evt_drop SHALL be unaffected.

Structure
REQ-027 Package click_pkg SHALL hold the FSM state enum (IDLE/COUNT/EMIT) and the constant DROP_CNT_W=8.
REQ-028 The window timer SHALL be a sub-module click_timer with ports clk, rst_n, clr, en and done (done when count==CLICK_WINDOW-1); the FSM stays in click_classifier.

Verification
REQ-029 All scenarios SHALL run with CLICK_WINDOW=8 and MAX_CLICKS=3.
REQ-030 Single pulse at cycle 10, evt_ready=1 -> evt_valid=1 at cycle 18 only, evt_clicks=1, then IDLE.
REQ-031 Pulses at cycles 10, 14 and 17 -> evt_valid at cycle 25, evt_clicks=3; a fourth pulse at 20 -> evt_valid at 28, evt_clicks=3, evt_drop never 1.
REQ-032 Pulse at 10 and 18 (timeout cycle) -> no event at 18; event at 26 with evt_clicks=2.
REQ-033 evt_ready=0 with the event pending, pulse at 20 -> evt_drop=1 at 21, evt_clicks unchanged; with DROP_CNT_EN, drop_cnt=1.
REQ-034 Pending event, evt_ready=1 and pls_in=1 in the same cycle -> event accepted, new window starts, next event evt_clicks=1 eight cycles later.
REQ-035 rst_n low at cycle 14 after a pulse at 10, released at 16 -> no event ever emitted, all outputs 0.

Source files
------------

// File: rtl/click_pkg.sv
// ============================================================================
// click_pkg : shared types and constants for the click classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package click_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/click_timer.sv
// ============================================================================
// click_timer : inter-click window counter, saturates at CLICK_WINDOW-1
// Rev 1.0
// ============================================================================
`default_nettype none

module click_timer #(
    parameter int CLICK_WINDOW = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int TIMER_W = (CLICK_WINDOW > 1) ? $clog2(CLICK_WINDOW) : 1;
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLICK_WINDOW - 1);

    logic [TIMER_W-1:0] count;

    // Holding at LAST keeps the counter from wrapping while the FSM decides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/click_classifier.sv
// ============================================================================
// click_classifier : groups debounced press pulses into multi-click events
// Optional macro CLICK_CLASSIFIER_DROP_CNT_EN adds a saturating drop counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module click_classifier
    import click_pkg::*;
#(
    parameter int CLICK_WINDOW = 25_000_000,
    parameter int MAX_CLICKS   = 3,
    localparam int CNT_W       = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pls_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_clicks,
    output logic             evt_drop
`ifdef CLICK_CLASSIFIER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CLICKS);

    state_t           state;
    logic [CNT_W-1:0] clicks;
    logic             timer_done;
    logic             timer_clr;
    logic             timer_en;

    // Any accepted pulse restarts the window; outside COUNT the timer idles at 0.
    assign timer_clr = pls_in || (state != COUNT);
    assign timer_en  = (state == COUNT);

    click_timer #(
        .CLICK_WINDOW(CLICK_WINDOW)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (timer_clr),
        .en   (timer_en),
        .done (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clicks     <= '0;
            evt_valid  <= 1'b0;
            evt_clicks <= '0;
            evt_drop   <= 1'b0;
        end else begin
            evt_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (pls_in) begin
                        clicks <= ONE;
                        state  <= COUNT;
                    end
                end
                COUNT: begin
                    // A pulse on the timeout cycle wins and restarts the window.
                    if (pls_in) begin
                        if (clicks != MAX_CNT) begin
                            clicks <= clicks + ONE;
                        end
                    end else if (timer_done) begin
                        state      <= EMIT;
                        evt_valid  <= 1'b1;
                        evt_clicks <= clicks;
                    end
                end
                EMIT: begin
                    if (evt_ready) begin
                        evt_valid  <= 1'b0;
                        evt_clicks <= '0;
                        if (pls_in) begin
                            state  <= COUNT;
                            clicks <= ONE;
                        end else begin
                            state  <= IDLE;
                            clicks <= '0;
                        end
                    end else if (pls_in) begin
                        evt_drop <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clicks     <= '0;
                    evt_valid  <= 1'b0;
                    evt_clicks <= '0;
                end
            endcase
        end
    end

`ifdef CLICK_CLASSIFIER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (evt_drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    // Discards are reported through evt_drop only.
`endif

endmodule

`default_nettype wire
